// File: rtl/mby_gmm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mby_gmm_pkg
// Brief    : Shared constants, injection entry layout and helpers for the GMM
//            tag / pod-pointer ring stops.
// Revision : 1.0 - initial release
// ============================================================================
package mby_gmm_pkg;

    // Deepest repeater pipe a ring stop may be built with
    localparam int MBY_RING_STAGE_MAX_PIPE = 4;

    // Geometry of the default (two-channel, 64-bit) ring stop
    localparam int MBY_RING_DEF_CH_W   = 1;
    localparam int MBY_RING_DEF_DATA_W = 64;

    // Width of the channel selector on the injection port
    function automatic int ring_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Injection FIFO entry for the default geometry; stops with other widths
    // declare the same {ch, data} layout sized to their own parameters.
    typedef struct packed {
        logic [MBY_RING_DEF_CH_W-1:0]   ch;
        logic [MBY_RING_DEF_DATA_W-1:0] data;
    } mby_ring_inj_t;

endpackage
`default_nettype wire

// File: rtl/mby_gmm_ring_inj_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mby_gmm_ring_inj_fifo
// Brief    : Synchronous in-order FIFO holding local ring injection entries,
//            with fill-level output and no full-to-ready bypass.
// Revision : 1.0 - initial release
// ============================================================================
module mby_gmm_ring_inj_fifo
    import mby_gmm_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = mby_ring_inj_t
) (
    input  logic                   cclk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  ENTRY_T                 push_data_i,
    input  logic                   pop_i,
    output ENTRY_T                 head_o,
    output logic                   ready_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    ENTRY_T        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push_fire;
    logic          pop_fire;

    // Ready looks only at the registered fill level, so a pop at full does
    // not open the door in the same cycle.
    assign ready_o   = (count_q < FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign push_fire = push_i && ready_o;
    assign pop_fire  = pop_i && !empty_o;

    // Fill level next state: simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and fill level; reset discards all queued entries
    always_ff @(posedge cclk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_fire)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Entry storage; validity is defined by the pointers, so no reset needed
    always_ff @(posedge cclk) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/mby_gmm_ring_stage.sv
`default_nettype none
// ============================================================================
// Module   : mby_gmm_ring_stage
// Brief    : N-channel GMM ring stop: PIPE_DEPTH repeater flops per channel,
//            local injection into empty slots at stage 0, and an upstream
//            stall request when the injection head stays blocked.
// Revision : 1.0 - initial release
// ============================================================================
module mby_gmm_ring_stage
    import mby_gmm_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DATA_W       = 64,
    parameter int PIPE_DEPTH   = 1,
    parameter int INJ_DEPTH    = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                          cclk,
    input  logic                          reset_n,
    input  logic [NUM_CH-1:0]             ring_in_valid,
    input  logic [NUM_CH*DATA_W-1:0]      ring_in_data,
    output logic [NUM_CH-1:0]             ring_out_valid,
    output logic [NUM_CH*DATA_W-1:0]      ring_out_data,
    input  logic                          inj_valid,
    input  logic [ring_ch_w(NUM_CH)-1:0]  inj_ch,
    input  logic [DATA_W-1:0]             inj_data,
    output logic                          inj_ready,
    output logic [NUM_CH-1:0]             stall_req_out,
    output logic [$clog2(INJ_DEPTH):0]    inj_occupancy,
    output logic [31:0]                   inj_count
);

    localparam int            CH_W       = ring_ch_w(NUM_CH);
    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } inj_entry_t;

    // ---------------------------------------------------------------- checks
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > MBY_RING_STAGE_MAX_PIPE) begin : g_bad_pipe
        $error("mby_gmm_ring_stage: PIPE_DEPTH=%0d outside 1..%0d", PIPE_DEPTH, MBY_RING_STAGE_MAX_PIPE);
    end
    if (INJ_DEPTH < 2 || (INJ_DEPTH & (INJ_DEPTH - 1)) != 0) begin : g_bad_inj_depth
        $error("mby_gmm_ring_stage: INJ_DEPTH=%0d must be a power of 2 >= 2", INJ_DEPTH);
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
        $error("mby_gmm_ring_stage: STARVE_LIMIT=%0d must be >= 1", STARVE_LIMIT);
    end
    if (NUM_CH < 1 || DATA_W < 1) begin : g_bad_geom
        $error("mby_gmm_ring_stage: NUM_CH and DATA_W must be >= 1");
    end

    // ------------------------------------------------------------ injection
    inj_entry_t                push_entry;
    inj_entry_t                head;
    logic                      fifo_empty;
    logic                      head_legal;
    logic                      head_occupied;
    logic                      head_blocked;
    logic                      fifo_pop;
    logic                      inj_fire;

    assign push_entry = {inj_ch, inj_data};

    mby_gmm_ring_inj_fifo #(
        .DEPTH   (INJ_DEPTH),
        .ENTRY_T (inj_entry_t)
    ) u_inj_fifo (
        .cclk        (cclk),
        .reset_n     (reset_n),
        .push_i      (inj_valid),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .ready_o     (inj_ready),
        .empty_o     (fifo_empty),
        .count_o     (inj_occupancy)
    );

    // A head naming a nonexistent channel is popped and discarded without
    // touching the ring; a legal head waits for a bubble on its channel.
    assign head_legal    = (32'(head.ch) < NUM_CH);
    assign head_occupied = head_legal && ring_in_valid[head.ch];
    assign head_blocked  = !fifo_empty && head_occupied;
    assign fifo_pop      = !fifo_empty && !head_occupied;
    assign inj_fire      = fifo_pop && head_legal;

    // ------------------------------------------------------ stage-0 merge
    logic [NUM_CH-1:0]        s0_valid;
    logic [NUM_CH*DATA_W-1:0] s0_data;

    // Drop the head payload into its target slot only when that slot is empty
    always_comb begin
        s0_valid = ring_in_valid;
        s0_data  = ring_in_data;
        for (int c = 0; c < NUM_CH; c++) begin
            if (inj_fire && (32'(head.ch) == c)) begin
                s0_valid[c]                 = 1'b1;
                s0_data[c*DATA_W +: DATA_W] = head.data;
            end
        end
    end

    // ------------------------------------------------------ repeater pipe
    for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_pipe
        logic [NUM_CH-1:0]        valid_q;
        logic [NUM_CH*DATA_W-1:0] data_q;
        logic [NUM_CH-1:0]        valid_d;
        logic [NUM_CH*DATA_W-1:0] data_d;

        if (s == 0) begin : g_first
            assign valid_d = s0_valid;
            assign data_d  = s0_data;
        end else begin : g_next
            assign valid_d = g_pipe[s-1].valid_q;
            assign data_d  = g_pipe[s-1].data_q;
        end

        // One repeater flop; reset clears payload too so no stale slot survives
        always_ff @(posedge cclk) begin
            if (!reset_n) begin
                valid_q <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
    end

    assign ring_out_valid = g_pipe[PIPE_DEPTH-1].valid_q;
    assign ring_out_data  = g_pipe[PIPE_DEPTH-1].data_q;

    // ------------------------------------------------- starvation / stall
    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
    logic [NUM_CH-1:0] stall_q;
    logic [NUM_CH-1:0] stall_d;
    logic [31:0]       inj_count_q;
    logic [31:0]       inj_count_d;

    // Count consecutive blocked cycles of the current head, saturating
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (head_blocked && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Ask upstream for a bubble on the head's channel once starved; one-hot
    always_comb begin
        stall_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            stall_d[c] = head_blocked && (starve_q == STARVE_MAX) && (32'(head.ch) == c);
        end
    end

    assign inj_count_d = inj_count_q + 32'(inj_fire);

    // Starvation counter, stall request and injection count registers
    always_ff @(posedge cclk) begin
        if (!reset_n) begin
            starve_q    <= '0;
            stall_q     <= '0;
            inj_count_q <= '0;
        end else begin
            starve_q    <= starve_d;
            stall_q     <= stall_d;
            inj_count_q <= inj_count_d;
        end
    end

    assign stall_req_out = stall_q;
    assign inj_count     = inj_count_q;

    // An accepted entry with an out-of-range channel will be silently dropped
    ILLEGAL_INJ_CH: assert property (@(posedge cclk) disable iff (!reset_n)
        !(inj_valid && inj_ready && (32'(inj_ch) >= NUM_CH)))
        else $warning("mby_gmm_ring_stage: accepted inj_ch=%0d with NUM_CH=%0d, entry will be dropped",
                      inj_ch, NUM_CH);

endmodule
`default_nettype wire

// File: tb/tb_mby_gmm_ring_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mby_gmm_ring_stage
// Brief    : Directed self-checking bench for mby_gmm_ring_stage
//            (NUM_CH=3, DATA_W=16, PIPE_DEPTH=3, INJ_DEPTH=4, STARVE_LIMIT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mby_gmm_ring_stage;

    logic        cclk = 1'b0;
    logic        reset_n;
    logic [2:0]  rv;
    logic [47:0] rd;
    logic [2:0]  ring_out_valid;
    logic [47:0] ring_out_data;
    logic        inj_valid;
    logic [1:0]  inj_ch;
    logic [15:0] inj_data;
    logic        inj_ready;
    logic [2:0]  stall_req_out;
    logic [2:0]  inj_occupancy;
    logic [31:0] inj_count;

    int checks = 0;
    int errors = 0;

    always #5 cclk = ~cclk;

    mby_gmm_ring_stage #(
        .NUM_CH       (3),
        .DATA_W       (16),
        .PIPE_DEPTH   (3),
        .INJ_DEPTH    (4),
        .STARVE_LIMIT (16)
    ) dut (
        .cclk           (cclk),
        .reset_n        (reset_n),
        .ring_in_valid  (rv),
        .ring_in_data   (rd),
        .ring_out_valid (ring_out_valid),
        .ring_out_data  (ring_out_data),
        .inj_valid      (inj_valid),
        .inj_ch         (inj_ch),
        .inj_data       (inj_data),
        .inj_ready      (inj_ready),
        .stall_req_out  (stall_req_out),
        .inj_occupancy  (inj_occupancy),
        .inj_count      (inj_count)
    );

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; rv = '0; rd = '0;
        inj_valid = 1'b0; inj_ch = '0; inj_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_valid", 64'(ring_out_valid), 0);
        chk("rst_data",  64'(ring_out_data), 0);
        chk("rst_stall", 64'(stall_req_out), 0);
        chk("rst_occ",   64'(inj_occupancy), 0);
        chk("rst_count", 64'(inj_count), 0);
        chk("rst_ready", 64'(inj_ready), 1);

        // Pass-through: 3-cycle latency, valid and data together
        reset_n = 1'b1;
        rv = 3'b011; rd = {16'h0000, 16'h005A, 16'h00A5};
        tick();
        rv = '0; rd = '0;
        chk("pt_lat1", 64'(ring_out_valid), 0);
        tick();
        chk("pt_lat2", 64'(ring_out_valid), 0);
        tick();
        chk("pt_valid", 64'(ring_out_valid), 3'b011);
        chk("pt_data",  64'(ring_out_data), 48'h0000_005A_00A5);
        tick();
        chk("pt_drain", 64'(ring_out_valid), 0);
        chk("pt_count", 64'(inj_count), 0);

        // Injection into a bubble on channel 1
        rv = 3'b101; rd = {16'h3333, 16'h0000, 16'h1111};
        inj_valid = 1'b1; inj_ch = 2'd1; inj_data = 16'h1234;
        tick();
        inj_valid = 1'b0;
        chk("inj_occ1", 64'(inj_occupancy), 1);
        tick();
        chk("inj_occ0", 64'(inj_occupancy), 0);
        chk("inj_cnt1", 64'(inj_count), 1);
        tick();
        chk("inj_early", 64'(ring_out_valid), 3'b101);
        tick();
        chk("inj_valid", 64'(ring_out_valid), 3'b111);
        chk("inj_data",  64'(ring_out_data), 48'h3333_1234_1111);
        rv = '0; rd = '0;

        // Full FIFO behind a fully occupied ring
        rv = 3'b111; rd = {16'hBBBB, 16'hAAAA, 16'h9999};
        inj_valid = 1'b1; inj_ch = 2'd0; inj_data = 16'h00C0;
        for (int k = 0; k < 6; k++) begin
            chk("full_ready", 64'(inj_ready), (k < 4) ? 64'd1 : 64'd0);
            tick();
            if (k < 4) inj_data = 16'h00C1 + 16'(k);
        end
        chk("full_occ",   64'(inj_occupancy), 4);
        chk("full_stall", 64'(stall_req_out), 0);
        rv = 3'b110;
        tick();
        chk("free_occ",   64'(inj_occupancy), 3);
        chk("free_ready", 64'(inj_ready), 1);
        tick();
        chk("push_pop_occ", 64'(inj_occupancy), 3);
        inj_valid = 1'b0; rv = '0; rd = '0;
        tick();
        chk("full_out_valid", 64'(ring_out_valid), 3'b111);
        chk("full_out_data",  64'(ring_out_data), 48'hBBBB_AAAA_00C0);
        tick(); tick();
        chk("full_drain_occ", 64'(inj_occupancy), 0);
        chk("full_count",     64'(inj_count), 6);

        // Starvation: channel 0 permanently occupied
        rv = 3'b001; rd = '0;
        inj_valid = 1'b1; inj_ch = 2'd0; inj_data = 16'h5555;
        tick();
        inj_valid = 1'b0;
        chk("stv_occ", 64'(inj_occupancy), 1);
        repeat (16) tick();
        chk("stv_not_yet", 64'(stall_req_out), 0);
        tick();
        chk("stv_set", 64'(stall_req_out), 3'b001);
        tick();
        chk("stv_hold", 64'(stall_req_out), 3'b001);
        rv = '0;
        tick();
        chk("stv_clear", 64'(stall_req_out), 0);
        chk("stv_occ0",  64'(inj_occupancy), 0);
        chk("stv_count", 64'(inj_count), 7);

        // Illegal channel: accepted, then dropped without touching the ring
        inj_valid = 1'b1; inj_ch = 2'd3; inj_data = 16'hDEAD;
        tick();
        inj_valid = 1'b0;
        chk("ill_occ1", 64'(inj_occupancy), 1);
        tick();
        chk("ill_occ0",  64'(inj_occupancy), 0);
        chk("ill_count", 64'(inj_count), 7);
        tick(); tick();
        chk("ill_valid", 64'(ring_out_valid), 0);
        chk("ill_data",  64'(ring_out_data), 0);

        // Counter wrap from 0xFFFFFFFF
        force dut.inj_count_d = 32'hFFFF_FFFF;
        tick();
        release dut.inj_count_d;
        chk("wrap_preload", 64'(inj_count), 32'hFFFF_FFFF);
        inj_valid = 1'b1; inj_ch = 2'd2; inj_data = 16'h0042;
        tick();
        inj_valid = 1'b0;
        tick();
        chk("wrap_count", 64'(inj_count), 0);
        tick(); tick();
        chk("wrap_valid", 64'(ring_out_valid), 3'b100);
        chk("wrap_data",  64'(ring_out_data), 48'h0042_0000_0000);

        // Reset mid-operation with queued entries and a full pipe
        rv = 3'b111; rd = {16'h7777, 16'h6666, 16'h5555};
        inj_valid = 1'b1; inj_ch = 2'd0; inj_data = 16'h0E0E;
        tick(); tick(); tick();
        chk("mid_occ3", 64'(inj_occupancy), 3);
        inj_valid = 1'b0; rv = '0; rd = '0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_valid", 64'(ring_out_valid), 0);
        chk("mid_data",  64'(ring_out_data), 0);
        chk("mid_occ",   64'(inj_occupancy), 0);
        chk("mid_ready", 64'(inj_ready), 1);
        chk("mid_stall", 64'(stall_req_out), 0);
        repeat (4) tick();
        chk("mid_no_stale", 64'(ring_out_valid), 0);
        chk("mid_occ_after", 64'(inj_occupancy), 0);
        chk("mid_count", 64'(inj_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
